// File: rtl/axis_pkg.sv
// Shared constants for the AXI write master: burst encodings, response codes
// and the one-hot state layout used by axis_write_addr.
package axis_pkg;

  // Bit position of each state inside the one-hot state vector.
  localparam int IDX_IDLE   = 0;
  localparam int IDX_SETUP  = 1;
  localparam int IDX_ADDR   = 2;
  localparam int IDX_RESP   = 3;
  localparam int IDX_DONE   = 4;
  localparam int NUM_STATES = 5;

  typedef enum logic [NUM_STATES-1:0] {
    ST_IDLE  = NUM_STATES'(1 << IDX_IDLE),
    ST_SETUP = NUM_STATES'(1 << IDX_SETUP),
    ST_ADDR  = NUM_STATES'(1 << IDX_ADDR),
    ST_RESP  = NUM_STATES'(1 << IDX_RESP),
    ST_DONE  = NUM_STATES'(1 << IDX_DONE)
  } wa_state_t;

  // AXI burst type for incrementing bursts.
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI write response code for a successful write.
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // AWSIZE encoding (log2 of bytes per beat) for a given AXI data width.
  function automatic int awsize_f(input int axiDataWidth);
    return $clog2(axiDataWidth / 8);
  endfunction

endpackage

// File: rtl/axis_write_addr.sv
// AXI write-address stage: splits one stream transfer (base byte address plus
// length in stream words) into maximum-size INCR bursts on the AW channel and
// forwards the word length to the neighbouring write-data stage.
// Optional build macro AXIS_WRITE_ADDR_BRESP_EN adds outstanding-burst
// tracking on the B channel, a RESP wait state and the resp_err output.
module axis_write_addr
  import axis_pkg::*;
#(
  parameter int CFG_AWIDTH     = 32,
  parameter int CFG_DWIDTH     = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int WIDTH_SHIFT    = 1,
  parameter int OUTSTD_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CFG_AWIDTH-1:0]    cfg_address,
  input  logic [CFG_DWIDTH-1:0]    cfg_length,
  input  logic                     cfg_val,
  output logic                     cfg_rdy,
  output logic [CFG_DWIDTH-1:0]    data_cfg_length,
  output logic                     data_cfg_val,
  input  logic                     data_cfg_rdy,
  output logic [CFG_AWIDTH-1:0]    axi_awaddr,
  output logic [AXI_LEN_WIDTH-1:0] axi_awlen,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  input  logic [1:0]               axi_bresp,
  input  logic                     axi_bvalid,
  output logic                     axi_bready,
  output logic                     busy,
  output logic                     done
`ifdef AXIS_WRITE_ADDR_BRESP_EN
  ,
  output logic                     resp_err
`endif
);

  // Bursts are aligned to their own size, which is at most 2 KB for the
  // default widths, so a burst can never straddle a 4 KB boundary.
  localparam int AWSIZE      = awsize_f(AXI_DATA_WIDTH);
  localparam int ALIGN_BITS  = AWSIZE + AXI_LEN_WIDTH;
  localparam logic [CFG_AWIDTH-1:0] BURST_BYTES = CFG_AWIDTH'(1) << ALIGN_BITS;
  localparam logic [CFG_AWIDTH-1:0] ALIGN_MASK  = ~(BURST_BYTES - CFG_AWIDTH'(1));
  localparam logic [CFG_DWIDTH-1:0] MAX_BEATS   = CFG_DWIDTH'(1) << AXI_LEN_WIDTH;
  localparam logic [CFG_DWIDTH:0]   ROUND_UP    = (CFG_DWIDTH+1)'((1 << WIDTH_SHIFT) - 1);

  // The beat/word ratio is given twice (widths and shift); refuse to build
  // when they disagree, since the rounding below trusts WIDTH_SHIFT alone.
  if (((AXI_DATA_WIDTH >> WIDTH_SHIFT) != DATA_WIDTH) || (OUTSTD_WIDTH < 1)) begin : g_param_check
    $error("axis_write_addr: WIDTH_SHIFT does not match AXI_DATA_WIDTH/DATA_WIDTH");
  end

  wa_state_t state_q, state_d;
  logic [CFG_AWIDTH-1:0] addr_q, addr_d;
  logic [CFG_DWIDTH-1:0] beatsLeft_q, beatsLeft_d;

  logic                  isIdle;
  logic                  isAddr;
  logic                  isDone;
  logic                  cfgAccept;
  logic                  awStall;
  logic                  awFire;
  logic [CFG_DWIDTH-1:0] burstBeats;
  logic [CFG_DWIDTH-1:0] beatsRounded;
  logic                  respIdle;
  wa_state_t             lastBurstState;

  assign isIdle = (state_q == ST_IDLE);
  assign isAddr = (state_q == ST_ADDR);
  assign isDone = (state_q == ST_DONE);

  assign cfg_rdy         = isIdle & data_cfg_rdy & ~rst;
  assign cfgAccept       = cfg_val & cfg_rdy;
  assign data_cfg_val    = cfgAccept & (|cfg_length);
  assign data_cfg_length = cfg_length;

  assign burstBeats   = (beatsLeft_q > MAX_BEATS) ? MAX_BEATS : beatsLeft_q;
  assign beatsRounded = CFG_DWIDTH'(({1'b0, beatsLeft_q} + ROUND_UP) >> WIDTH_SHIFT);

  assign axi_awvalid = isAddr & ~awStall;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = AXI_LEN_WIDTH'(burstBeats - CFG_DWIDTH'(1));
  assign awFire      = axi_awvalid & axi_awready;

  assign axi_bready = 1'b1;
  assign busy       = ~isIdle;
  assign done       = isDone;

`ifdef AXIS_WRITE_ADDR_BRESP_EN
  logic [OUTSTD_WIDTH-1:0] outstd_q, outstd_d;
  logic                    respErr_q, respErr_d;
  logic                    bFire;

  assign bFire          = axi_bvalid & axi_bready;
  assign awStall        = (outstd_q == '1);
  assign respIdle       = (outstd_q == '0);
  assign lastBurstState = ST_RESP;
  assign resp_err       = respErr_q;

  // Outstanding-burst count and sticky error flag, cleared by a new config.
  always_comb begin
    outstd_d  = outstd_q;
    respErr_d = respErr_q;
    if (awFire && !bFire) begin
      outstd_d = outstd_q + OUTSTD_WIDTH'(1);
    end else if (bFire && !awFire && !respIdle) begin
      outstd_d = outstd_q - OUTSTD_WIDTH'(1);
    end
    if (cfgAccept) begin
      respErr_d = 1'b0;
    end else if (bFire && (axi_bresp != AXI_RESP_OKAY)) begin
      respErr_d = 1'b1;
    end
  end

  // Response-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstd_q  <= '0;
      respErr_q <= 1'b0;
    end else begin
      outstd_q  <= outstd_d;
      respErr_q <= respErr_d;
    end
  end

  logic unusedConst;
  assign unusedConst = ^AXI_BURST_INCR;
`else
  assign awStall        = 1'b0;
  assign respIdle       = 1'b1;
  assign lastBurstState = ST_DONE;

  logic unusedInputs;
  assign unusedInputs = ^{axi_bresp, axi_bvalid, AXI_BURST_INCR, AXI_RESP_OKAY};
`endif

  // Next-state logic for the FSM and the burst address/beat counters.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beatsLeft_d = beatsLeft_q;
    case (state_q)
      ST_IDLE: begin
        if (cfgAccept) begin
          addr_d      = cfg_address;
          beatsLeft_d = cfg_length;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        addr_d      = addr_q & ALIGN_MASK;
        beatsLeft_d = beatsRounded;
        state_d     = (beatsLeft_q == '0) ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: begin
        if (awFire) begin
          addr_d      = addr_q + BURST_BYTES;
          beatsLeft_d = beatsLeft_q - burstBeats;
          if (beatsLeft_q == burstBeats) begin
            state_d = lastBurstState;
          end
        end
      end
`ifdef AXIS_WRITE_ADDR_BRESP_EN
      ST_RESP: begin
        if (respIdle) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        beatsLeft_d = '0;
      end
    endcase
  end

  // State, address and remaining-beat registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      beatsLeft_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beatsLeft_q <= beatsLeft_d;
    end
  end

endmodule
